// File: rtl/lpcdec_pkg.sv
// rtl/lpcdec_pkg.sv - shared constants, FSM state type and saturation helper for the LPC decoder
package lpcdec_pkg;

    localparam int ORDER  = 10;
    localparam int COEF_W = 16;
    localparam int FRAC   = 12;
    localparam int ACC_W  = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 40'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -40'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/lpc_exc_gen.sv
// rtl/lpc_exc_gen.sv - excitation source: pitch counter, optional LFSR noise (LPCDEC_NOISE_EN)
module lpc_exc_gen
    import lpcdec_pkg::*;
#(
    parameter logic signed [15:0] IMP_AMP     = 16'sd8192,
    parameter int                 NOISE_SHIFT = 3,
    parameter logic [15:0]        LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic               voiced,
    input  logic [15:0]        pitch,
    output logic signed [15:0] exc
);

    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        pitch_eff;
    logic signed [15:0] noise;

    assign pitch_eff = (pitch < 16'd2) ? 16'd2 : pitch;

    // >= rather than == so a shorter new pitch wraps immediately instead of running to 65535
    always_comb begin
        cnt_d = cnt_q;
        if (adv) begin
            cnt_d = (cnt_q >= pitch_eff - 16'd1) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef LPCDEC_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise = $signed(lfsr_q) >>> NOISE_SHIFT;
`else
    logic unused_cfg;
    assign unused_cfg = ^{LFSR_SEED, 32'(NOISE_SHIFT)};
    assign noise      = 16'sd0;
`endif

    assign exc = voiced ? ((cnt_q == 16'd0) ? IMP_AMP : 16'sd0) : noise;

endmodule

// File: rtl/lpcdec.sv
// rtl/lpcdec.sv - 10th-order LPC all-pole synthesis filter, one sample per sample_req (LPCDEC_NOISE_EN selects noise)
module lpcdec
    import lpcdec_pkg::*;
#(
    parameter logic signed [15:0] IMP_AMP     = 16'sd8192,
    parameter int                 NOISE_SHIFT = 3,
    parameter logic [15:0]        LFSR_SEED   = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_valid,
    output logic         frame_ready,
    input  logic [159:0] coef,
    input  logic         voiced,
    input  logic [15:0]  pitch,
    input  logic         sample_req,
    output logic [15:0]  y_out,
    output logic         y_valid,
    output logic         overrun
);

    state_t                    state_q, state_d;
    logic [3:0]                k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        e_q, e_d;
    logic signed [15:0]        ysat_q, ysat_d;
    logic                      pend_q, pend_d;
    logic [15:0]               y_out_q, y_out_d;
    logic                      y_valid_q, y_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_ready_q, frame_ready_d;
    logic signed [COEF_W-1:0]  coef_q [ORDER];
    logic signed [COEF_W-1:0]  coef_d [ORDER];
    logic signed [15:0]        hist_q [ORDER];
    logic signed [15:0]        hist_d [ORDER];
    logic                      voiced_q, voiced_d;
    logic [15:0]               pitch_q, pitch_d;

    logic                      accept;
    logic                      start;
    logic                      exc_voiced;
    logic [15:0]               exc_pitch;
    logic signed [15:0]        exc;
    logic signed [31:0]        prod;

    assign accept = frame_valid && frame_ready_q;
    assign start  = sample_req && (state_q == IDLE);

    // A frame arriving with the sample drives the excitation directly so that sample uses it
    assign exc_voiced = accept ? voiced : voiced_q;
    assign exc_pitch  = accept ? pitch  : pitch_q;

    lpc_exc_gen #(
        .IMP_AMP     (IMP_AMP),
        .NOISE_SHIFT (NOISE_SHIFT),
        .LFSR_SEED   (LFSR_SEED)
    ) u_exc (
        .clk    (clk),
        .rst    (rst),
        .adv    (start),
        .voiced (exc_voiced),
        .pitch  (exc_pitch),
        .exc    (exc)
    );

    assign prod = coef_q[k_q] * hist_q[k_q];

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        acc_d         = acc_q;
        e_d           = e_q;
        ysat_d        = ysat_q;
        pend_d        = 1'b0;
        y_out_d       = y_out_q;
        y_valid_d     = 1'b0;
        overrun_d     = 1'b0;
        coef_d        = coef_q;
        hist_d        = hist_q;
        voiced_d      = voiced_q;
        pitch_d       = pitch_q;

        if (accept) begin
            for (int i = 0; i < ORDER; i++) begin
                coef_d[i] = coef[COEF_W*i +: COEF_W];
            end
            voiced_d = voiced;
            pitch_d  = pitch;
        end

        case (state_q)
            IDLE: begin
                if (sample_req) begin
                    e_d     = exc;
                    acc_d   = '0;
                    k_d     = 4'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                overrun_d = sample_req;
                acc_d     = acc_q + ACC_W'(prod);
                if (k_q == 4'(ORDER - 1)) begin
                    state_d = OUT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            OUT: begin
                overrun_d = sample_req;
                ysat_d    = sat16(ACC_W'(e_q) - (acc_q >>> FRAC));
                for (int i = ORDER - 1; i > 0; i--) begin
                    hist_d[i] = hist_q[i-1];
                end
                hist_d[0] = ysat_d;
                pend_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // One-stage output register keeps y_out stable until the moment y_valid rises
        if (pend_q) begin
            y_out_d   = ysat_q;
            y_valid_d = 1'b1;
        end

        frame_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= 4'd0;
            acc_q         <= '0;
            e_q           <= 16'sd0;
            ysat_q        <= 16'sd0;
            pend_q        <= 1'b0;
            y_out_q       <= 16'd0;
            y_valid_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_ready_q <= 1'b1;
            voiced_q      <= 1'b0;
            pitch_q       <= 16'd0;
            for (int i = 0; i < ORDER; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            acc_q         <= acc_d;
            e_q           <= e_d;
            ysat_q        <= ysat_d;
            pend_q        <= pend_d;
            y_out_q       <= y_out_d;
            y_valid_q     <= y_valid_d;
            overrun_q     <= overrun_d;
            frame_ready_q <= frame_ready_d;
            voiced_q      <= voiced_d;
            pitch_q       <= pitch_d;
            coef_q        <= coef_d;
            hist_q        <= hist_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign y_out       = y_out_q;
    assign y_valid     = y_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_lpcdec.sv
// tb/tb_lpcdec.sv - directed self-checking bench for lpcdec (expectations follow LPCDEC_NOISE_EN)
module tb_lpcdec;

    logic         clk;
    logic         rst;
    logic         frame_valid;
    logic         frame_ready;
    logic [159:0] coef;
    logic         voiced;
    logic [15:0]  pitch;
    logic         sample_req;
    logic [15:0]  y_out;
    logic         y_valid;
    logic         overrun;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    lpcdec dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .coef        (coef),
        .voiced      (voiced),
        .pitch       (pitch),
        .sample_req  (sample_req),
        .y_out       (y_out),
        .y_valid     (y_valid),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_frame(input logic signed [15:0] a1, input logic v, input logic [15:0] p);
        coef        = '0;
        coef[15:0]  = a1;
        voiced      = v;
        pitch       = p;
        frame_valid = 1'b1;
    endtask

    // Issues one request (plus any pending frame) and checks latency and the produced sample
    task automatic req_sample(input int exp_y, input string tag);
        int lat;
        @(negedge clk);
        sample_req = 1'b1;
        @(posedge clk);
        #1;
        sample_req  = 1'b0;
        frame_valid = 1'b0;
        lat = 0;
        while (!y_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) chk({tag, "_ready_busy"}, int'(frame_ready), 0);
        end
        chk({tag, "_lat"}, lat, 12);
        chk({tag, "_y"}, int'($signed(y_out)), exp_y);
    endtask

    int exp_a [9] = '{8192, 0, 0, 0, 8192, 0, 0, 0, 8192};
    int exp_b [5] = '{8192, 4096, 2048, 1024, 512};
    int exp_c [4] = '{8192, 16384, 32767, 32767};
`ifdef LPCDEC_NOISE_EN
    int exp_u [3] = '{-2660, 2872, -2448};
`else
    int exp_u [3] = '{0, 0, 0};
`endif

    initial begin
        int vcnt;
        rst         = 1'b1;
        frame_valid = 1'b0;
        coef        = '0;
        voiced      = 1'b0;
        pitch       = 16'd0;
        sample_req  = 1'b0;

        do_reset();
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_frame_ready", int'(frame_ready), 1);
        chk("rst_overrun", int'(overrun), 0);

        set_frame(16'sd0, 1'b1, 16'd4);
        for (int i = 0; i < 9; i++) req_sample(exp_a[i], $sformatf("impulse%0d", i));

        do_reset();
        set_frame(-16'sd2048, 1'b1, 16'd1000);
        for (int i = 0; i < 5; i++) req_sample(exp_b[i], $sformatf("decay%0d", i));

        do_reset();
        set_frame(-16'sd8192, 1'b1, 16'd2);
        for (int i = 0; i < 4; i++) req_sample(exp_c[i], $sformatf("sat%0d", i));

        do_reset();
        set_frame(16'sd0, 1'b1, 16'd4);
        @(negedge clk);
        sample_req = 1'b1;
        @(posedge clk);
        #1;
        sample_req  = 1'b0;
        frame_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 sample_req = 1'b1;
        @(posedge clk);
        #1 sample_req = 1'b0;
        chk("overrun_pulse", int'(overrun), 1);
        vcnt = 0;
        for (int i = 6; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) chk("overrun_clear", int'(overrun), 0);
            if (y_valid) begin
                vcnt++;
                chk("overrun_vtime", i, 12);
            end
        end
        chk("overrun_vcount", vcnt, 1);

        @(negedge clk);
        sample_req = 1'b1;
        @(posedge clk);
        #1 sample_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (y_valid) vcnt++;
        end
        chk("midmac_no_valid", vcnt, 0);
        chk("midmac_y_out", int'(y_out), 0);
        chk("midmac_ready", int'(frame_ready), 1);

        do_reset();
        set_frame(16'sd0, 1'b0, 16'd4);
        for (int i = 0; i < 3; i++) req_sample(exp_u[i], $sformatf("noise%0d", i));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
